// File: rtl/scroll_ctrl_pkg.sv
// Shared definitions for the scroll position path and the display stage that consumes it.
// The display stage uses POS_W and the direction encodings too.
package scroll_ctrl_pkg;

  localparam int POS_W = 3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // One step of the scroll position; arithmetic wraps naturally at POS_W bits.
  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p, input dir_t d);
    return (d == DIR_DOWN) ? p - POS_W'(1) : p + POS_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, debouncer and press detector for one active-low board pushbutton.
// level is the debounced pressed state; press pulses one cycle on each accepted press.
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic key_s1;
  logic key_s2;
  logic key_stable;
  logic [CNT_W-1:0] deb_cnt;

  // key_stable keeps the raw (active-low) polarity, so its reset value 1 means released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1     <= 1'b1;
      key_s2     <= 1'b1;
      key_stable <= 1'b1;
      deb_cnt    <= '0;
      press      <= 1'b0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      press  <= 1'b0;
      if (key_s2 != key_stable) begin
        if (deb_cnt == DEB_LAST) begin
          key_stable <= key_s2;
          deb_cnt    <= '0;
          press      <= ~key_s2;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign level = ~key_stable;

endmodule

// File: rtl/scroll_ctrl.sv
// Scroll position for the eight-digit hex display: steps modulo 8 on a debounced key press
// or an auto-scroll tick, in the switch-selected direction, with a direct switch load.
module scroll_ctrl
  import scroll_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_step_n,
  input  logic             sw_auto,
  input  logic             sw_dir,
  input  logic             sw_load,
  input  logic [POS_W-1:0] load_val,
  output logic [POS_W-1:0] pos,
  output logic             step_pulse,
  output logic             key_level
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             press_evt;
  logic             step_req;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_step_n),
    .level(key_level),
    .press(press_evt)
  );

  assign tick     = sw_auto & (div_cnt == DIV_LAST);
  assign step_req = press_evt | tick;

  // A load restarts the prescaler so the next auto step is a full period after the load ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (sw_load || !sw_auto || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos        <= '0;
      step_pulse <= 1'b0;
    end else if (sw_load) begin
      pos        <= load_val;
      step_pulse <= 1'b0;
    end else if (step_req) begin
      pos        <= pos_step(pos, dir_t'(sw_dir));
      step_pulse <= 1'b1;
    end else begin
      step_pulse <= 1'b0;
    end
  end

endmodule
